// File: rtl/stream_mux_rr_pkg.sv
// Shared package for stream_mux_rr: default parameters and channel-index width helper.
// STREAM_MUX_RR_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
package stream_mux_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int WIDTH_DEF = 4;

    function automatic int ch_w(int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational request arbiter with registered search pointer.
// STREAM_MUX_RR_FIXED_PRIO_EN: search always starts at index 0 and no pointer exists.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N = N_CH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic                  adv,
    output logic [N-1:0]          gnt,
    output logic [ch_w(N)-1:0]    gnt_idx
);

    localparam int W = ch_w(N);

    logic [W-1:0] start;
    logic [W-1:0] pos;
    logic         found;

`ifdef STREAM_MUX_RR_FIXED_PRIO_EN
    assign start = '0;
    wire unused = &{1'b0, clk, rst, adv};
`else
    logic [W-1:0] ptr;

    assign start = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
        end
    end
`endif

    // First requester at or after start, wrapping modulo N
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        pos     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = W'((int'(start) + k) % N);
            if (!found && req[pos]) begin
                found   = 1'b1;
                gnt_idx = pos;
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with arbitration and a registered output.
// STREAM_MUX_RR_FIXED_PRIO_EN switches the arbiter to fixed lowest-index priority.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*WIDTH-1:0]    in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [ch_w(N_CH)-1:0]    out_ch,
    input  logic                     out_ready
);

    localparam int CH_W = ch_w(N_CH);

    logic              load;
    logic              adv;
    logic [N_CH-1:0]   gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  sel_data;

    assign load     = !out_valid || out_ready;
    assign in_ready = (rst || !load) ? '0 : gnt;
    assign adv      = |in_ready;

    rr_arbiter #(
        .N       (N_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .adv     (adv),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A new word may replace the departing one on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (N_CH=4, WIDTH=4).
// Expectations follow STREAM_MUX_RR_FIXED_PRIO_EN when it is defined.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic [3:0] dv [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [3:0] hd, nd;
    logic [1:0] hc, nc;

    always #5 clk = ~clk;

    stream_mux_rr #(
        .N_CH      (4),
        .WIDTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [3:0] d, input logic [1:0] c);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_ch"},    32'(out_ch),    32'(c));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 16'hDCBA;
        out_ready = 1'b1;
        #1;
        chk("rst_ready0", 32'(in_ready), 0);
        tick;
        chk_out("rst", 1'b0, 4'h0, 2'd0);
        chk("rst_ready1", 32'(in_ready), 0);
        tick;
        rst = 1'b0;
        #1;
        chk("first_ready", 32'(in_ready), 32'h1);
        tick;
        chk_out("first", 1'b1, 4'hA, 2'd0);

`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk_out("rotate", 1'b1, dv[i%4], 2'(i % 4));
        end
        in_valid = 4'b0100;
        in_data  = 16'hD5BA;
        #1;
        chk("ch2_ready", 32'(in_ready), 32'h4);
        tick;
        chk_out("ch2", 1'b1, 4'h5, 2'd2);
        in_valid = 4'b1111;
        in_data  = 16'hDCBA;
        #1;
        chk("after2_ready", 32'(in_ready), 32'h8);
        tick;
        chk_out("after2", 1'b1, 4'hD, 2'd3);
        hd = 4'hD; hc = 2'd3;
`else
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_out("fixed", 1'b1, 4'hA, 2'd0);
        end
        in_valid = 4'b1111;
        hd = 4'hA; hc = 2'd0;
`endif
        nd = 4'hA; nc = 2'd0;

        out_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out("bp_hold", 1'b1, hd, hc);
            chk("bp_hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick;
        chk_out("bp_release", 1'b1, nd, nc);

        in_valid = 4'b0000;
        #1;
        chk("idle_ready", 32'(in_ready), 0);
        tick;
        chk_out("idle1", 1'b0, nd, nc);
        tick;
        chk_out("idle2", 1'b0, nd, nc);

        in_valid = 4'b1111;
        tick;
        chk("mid_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick;
        chk_out("mid_rst", 1'b0, 4'h0, 2'd0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        rst = 1'b0;
        tick;
        chk_out("post_rst", 1'b1, 4'hA, 2'd0);

`ifndef STREAM_MUX_RR_FIXED_PRIO_EN
        in_valid = 4'b1001;
        tick;
        chk_out("pair_a", 1'b1, 4'hD, 2'd3);
        tick;
        chk_out("pair_b", 1'b1, 4'hA, 2'd0);
        tick;
        chk_out("pair_c", 1'b1, 4'hD, 2'd3);
`else
        in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out("fixed_pair", 1'b1, 4'hA, 2'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer with valid/ready handshakes on every input and on the output, round-robin arbitration and a registered output stage. Generalises the static select multiplexers: instead of an external `sel`, the block picks among requesting channels itself, holds data until the consumer accepts it, and reports which channel each word came from. Sits between several producers and one shared consumer in the datapath.

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `WIDTH`, default 4: data width per channel, ≥1.
- `clk`  input  1: clock, all state on rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `in_valid`  input  N_CH: per-channel request.
- `in_data`  input  N_CH×WIDTH: packed, channel i at `[i*WIDTH +: WIDTH]`.
- `in_ready`  output  N_CH: per-channel accept; at most one bit high.
- `out_valid`  output  1: output register holds a word.
- `out_data`  output  WIDTH: registered data.
- `out_ch`  output  CH_W: source channel of `out_data`; CH_W = max(1, $clog2(N_CH)).
- `out_ready`  input  1: consumer accept.

## Operation
- Input transfer on channel i: `in_valid[i] && in_ready[i]` at a rising edge. Output transfer: `out_valid && out_ready`.
- `load = !out_valid || out_ready`: output register can take a new word this cycle.
- Arbiter: combinational. Searches `in_valid` starting at pointer `ptr`, wrapping modulo N_CH; the first requesting index is the winner. `in_ready[winner] = load`; all other `in_ready` bits are 0. No valid inputs: all `in_ready` are 0.
- On input transfer: `out_data <= in_data[winner]`, `out_ch <= winner`, `out_valid <= 1`, `ptr <= winner+1`, wrapping from N_CH-1 to 0.
- On output transfer with no input transfer: `out_valid <= 0`. Data and `out_ch` hold their values.
- `out_valid && !out_ready`: register holds. All `in_ready` are 0.
- Simultaneous output and input transfer: the new word replaces the old in the same edge. Throughput is 1 word per cycle.
- Channels not granted keep waiting. Producers must hold `in_valid` and data stable until accepted. The block does not check this.
- Reset: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`. `in_ready` is all 0 during the reset cycle. Reset mid-stream discards the held word.

## Timing
- Latency: 1 cycle. A word accepted at edge k is visible on `out_*` after edge k.
- `in_ready` depends combinationally on `in_valid`, `out_ready` and state. `out_*` come straight from flops.
- Fairness: when all N_CH channels request continuously and `out_ready=1`, grants rotate 0,1,…,N_CH-1,0. Each channel gets exactly one grant per N_CH cycles.
- Starvation bound: a continuously requesting channel is granted within N_CH output transfers.

## Configuration
- `STREAM_MUX_RR_FIXED_PRIO_EN`
  - Defined: the search always starts at index 0 (lowest index wins), and `ptr` is not implemented.
  - Undefined: round-robin as described above.
  - Handshake, latency and reset behaviour are identical in both modes.

## Structure
- Shared package `stream_mux_pkg`:
  - `function automatic int ch_w(int n)`, which returns max(1, $clog2(n)).
  - Default-parameter localparams.
- One sub-module, `rr_arbiter`:
  - Parameter `N`.
  - Ports `clk`, `rst`, `req[N]`, `adv` (transfer strobe), `gnt[N]` (one-hot), `gnt_idx`.
  - Owns `ptr` and the macro-controlled priority logic.
- The top level holds the output register and the data mux.

## Test plan
- Reset, with `in_valid=4'b1111` and `out_ready=1` held during `rst`: `out_valid=0` and `in_ready=0` in the reset cycle. First word after reset comes from channel 0, `out_ch=0`.
- All 4 channels valid, `in_data` = {3:D,2:C,1:B,0:A}, `out_ready=1` constant: `out_data` sequence A,B,C,D,A, `out_ch` 0,1,2,3,0, `out_valid` high every cycle after the first.
- Only channel 2 valid (data 5): accepted at once, `out_data=5`, `out_ch=2`. Next grant with all valid is channel 3.
- Backpressure: `out_ready=0` for 3 cycles with `out_valid=1`: `out_data` stable, `in_ready=0`. `out_ready=1`: a new word loads in the same cycle as the old one leaves.
- Idle: `in_valid=0`, `out_ready=1`: `out_valid` falls after one cycle, `out_data` holds its last value.
- `STREAM_MUX_RR_FIXED_PRIO_EN` defined, channels 0 and 3 both continuously valid: channel 0 is always granted, so `out_ch=0` every cycle.
